serial_txn_ctrl: RTL



---
 rtl/serial_pkg.sv | 21 ++
 rtl/serial_txn_ctrl_sync_edge.sv | 31 +++
 rtl/serial_txn_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transaction sequencer.
package serial_pkg;

    typedef enum logic [2:0] {
        Idle   = 3'd0,
        Load   = 3'd1,
        Start  = 3'd2,
        Run    = 3'd3,
        Finish = 3'd4
    } t_txn_state;

    typedef enum logic [1:0] {
        ErrNone     = 2'd0,
        ErrLength   = 2'd1,
        ErrUnderrun = 2'd2
    } t_txn_err;

    // Main clock must run at least this many times faster than the serial clock.
    localparam int MIN_CLK_RATIO = 16;

endpackage

// File: rtl/serial_txn_ctrl_sync_edge.sv
// Multi-stage synchroniser with rise/fall detection on the synchronised level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_async,
    output logic out_level,
    output logic out_rise,
    output logic out_fall
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Synchroniser chain plus one delayed copy of its output for edge detection.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            chain_r <= {STAGES{1'b0}};
            prev_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], in_async};
            prev_r  <= chain_r[STAGES-1];
        end
    end

    assign out_level = chain_r[STAGES-1];
    assign out_rise  = chain_r[STAGES-1] & ~prev_r;
    assign out_fall  = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/serial_txn_ctrl.sv
// Sequences one host transaction of N words through the 3-wire serial block:
// TX fetch with a one-word look-ahead, RX capture, clean end at a word boundary.
module serial_txn_ctrl
    import serial_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int MAX_WORDS = 16,
    parameter int CTR_W     = $clog2(MAX_WORDS) + 1
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_start,
    input  logic [CTR_W-1:0] in_num_words,
    output logic             out_busy,
    output logic             out_done,
    output logic [1:0]       out_error,
    input  logic [BITS-1:0]  in_tx_word,
    input  logic             in_tx_valid,
    output logic             out_tx_ready,
    output logic [BITS-1:0]  out_rx_word,
    output logic             out_rx_valid,
    output logic             out_ser_enable,
    output logic [BITS-1:0]  out_ser_parallel,
    input  logic             in_ser_ready,
    input  logic             in_ser_next_word,
    input  logic [BITS-1:0]  in_ser_parallel
);

    t_txn_state       state_r, state_s;
    t_txn_err         err_r;
    logic [CTR_W-1:0] num_words_r, words_fetched_r, words_sent_r;
    logic [BITS-1:0]  tx_cur_r, tx_nxt_r, rx_word_r;
    logic             nxt_full_r, done_r, rx_valid_r, rx_pending_r;
    logic             busy_s, enable_s, tx_ready_s, accept_s;
    logic             last_word_s, transfer_s, underrun_s, start_ok_s;
    logic             rdy_level_s, rdy_rise_s, rdy_fall_s;
    logic             nw_level_s, nw_rise_s, nw_fall_s;
    logic             sync_unused_s;

    sync_edge #(.STAGES(2)) u_sync_ready (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_async  (in_ser_ready),
        .out_level (rdy_level_s),
        .out_rise  (rdy_rise_s),
        .out_fall  (rdy_fall_s)
    );

    sync_edge #(.STAGES(2)) u_sync_next (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_async  (in_ser_next_word),
        .out_level (nw_level_s),
        .out_rise  (nw_rise_s),
        .out_fall  (nw_fall_s)
    );

    assign sync_unused_s = rdy_rise_s ^ nw_level_s;

    assign start_ok_s  = in_start && (in_num_words != {CTR_W{1'b0}})
                         && (in_num_words <= CTR_W'(MAX_WORDS));
    assign tx_ready_s  = busy_s && !nxt_full_r && (words_fetched_r < num_words_r);
    assign accept_s    = in_tx_valid && tx_ready_s;
    // Word k ends on a next_word rise; words_sent_r still holds k-1 at that moment.
    assign last_word_s = ((words_sent_r + CTR_W'(1)) >= num_words_r);
    assign transfer_s  = (state_r == Run) && nw_rise_s && !last_word_s && nxt_full_r;
    assign underrun_s  = (state_r == Run) && nw_rise_s && !last_word_s && !nxt_full_r;

    // FSM state register.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_r <= Idle;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            Idle: begin
                if (start_ok_s) state_s = Load;
                else            state_s = Idle;
            end
            Load: begin
                if (accept_s) state_s = Start;
                else          state_s = Load;
            end
            Start: begin
                if (rdy_fall_s) state_s = Run;
                else            state_s = Start;
            end
            Run: begin
                if (nw_rise_s && (last_word_s || !nxt_full_r)) state_s = Finish;
                else                                           state_s = Run;
            end
            Finish: begin
                if (rdy_level_s && !rx_pending_r) state_s = Idle;
                else                              state_s = Finish;
            end
            default: state_s = Idle;
        endcase
    end

    // FSM outputs decoded from the state register; enable follows reset asynchronously.
    always_comb begin
        busy_s   = 1'b0;
        enable_s = 1'b0;
        case (state_r)
            Idle:       begin busy_s = 1'b0; enable_s = 1'b0; end
            Load:       begin busy_s = 1'b1; enable_s = 1'b0; end
            Start, Run: begin busy_s = 1'b1; enable_s = 1'b1; end
            Finish:     begin busy_s = 1'b1; enable_s = 1'b0; end
            default:    begin busy_s = 1'b0; enable_s = 1'b0; end
        endcase
    end

    // TX path: current word, look-ahead holding register and fetch counter.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            tx_cur_r        <= {BITS{1'b0}};
            tx_nxt_r        <= {BITS{1'b0}};
            nxt_full_r      <= 1'b0;
            words_fetched_r <= {CTR_W{1'b0}};
        end else if (state_r == Idle) begin
            if (start_ok_s) begin
                nxt_full_r      <= 1'b0;
                words_fetched_r <= {CTR_W{1'b0}};
            end else begin
                nxt_full_r      <= nxt_full_r;
            end
        end else begin
            if (accept_s) begin
                words_fetched_r <= words_fetched_r + CTR_W'(1);
                if (state_r == Load) begin
                    tx_cur_r <= in_tx_word;
                end else begin
                    tx_nxt_r   <= in_tx_word;
                    nxt_full_r <= 1'b1;
                end
            end else begin
                words_fetched_r <= words_fetched_r;
            end
            // Transfer reads the old look-ahead; a same-cycle accept keeps it full.
            if (transfer_s) begin
                tx_cur_r <= tx_nxt_r;
                if (!accept_s) nxt_full_r <= 1'b0;
                else           nxt_full_r <= 1'b1;
            end else begin
                tx_cur_r <= (accept_s && (state_r == Load)) ? in_tx_word : tx_cur_r;
            end
        end
    end

    // Transaction control: length, sent-word count, error and done pulse.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            num_words_r  <= {CTR_W{1'b0}};
            words_sent_r <= {CTR_W{1'b0}};
            err_r        <= ErrNone;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                Idle: begin
                    if (in_start && (in_num_words == {CTR_W{1'b0}})) begin
                        done_r <= 1'b1;
                        err_r  <= ErrNone;
                    end else if (in_start && (in_num_words > CTR_W'(MAX_WORDS))) begin
                        done_r <= 1'b1;
                        err_r  <= ErrLength;
                    end else if (in_start) begin
                        num_words_r  <= in_num_words;
                        words_sent_r <= {CTR_W{1'b0}};
                        err_r        <= ErrNone;
                    end else begin
                        err_r <= err_r;
                    end
                end
                Run: begin
                    if (nw_rise_s && (words_sent_r < num_words_r)) begin
                        words_sent_r <= words_sent_r + CTR_W'(1);
                    end else begin
                        words_sent_r <= words_sent_r;
                    end
                    if (underrun_s) err_r <= ErrUnderrun;
                    else            err_r <= err_r;
                end
                Finish: begin
                    if (state_s == Idle) done_r <= 1'b1;
                    else                 done_r <= 1'b0;
                end
                default: done_r <= 1'b0;
            endcase
        end
    end

    // RX capture: one pulse per word whose end (next_word rise) was seen this transaction.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            rx_word_r    <= {BITS{1'b0}};
            rx_valid_r   <= 1'b0;
            rx_pending_r <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            if ((state_r == Run) && nw_rise_s) begin
                rx_pending_r <= 1'b1;
            end else if (nw_fall_s && rx_pending_r) begin
                rx_pending_r <= 1'b0;
                rx_word_r    <= in_ser_parallel;
                rx_valid_r   <= 1'b1;
            end else begin
                rx_pending_r <= rx_pending_r;
            end
        end
    end

    assign out_busy         = busy_s;
    assign out_done         = done_r;
    assign out_error        = err_r;
    assign out_tx_ready     = tx_ready_s;
    assign out_rx_word      = rx_word_r;
    assign out_rx_valid     = rx_valid_r;
    assign out_ser_enable   = enable_s;
    assign out_ser_parallel = tx_cur_r;

endmodule
